// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EX stage.
// Latency: MULT_CYCLES or DIV_CYCLES edges from the accepting edge to the HI/LO write.
// No queueing: start and MTHI/MTLO are ignored while busy; stall_req holds back HI/LO users.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, next_state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [WIDTH-1:0]   calc_hi, calc_lo;
  logic               accept, done;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   quot_s, rem_s, quot_u, rem_u;
  logic [WIDTH-1:0]   div_b;
  logic               div_zero, div_ovf;

  // Result datapath: the whole result is formed from the live operands and
  // captured on the accepting edge, then held until the counter expires.
  always_comb begin
    div_zero = (b == '0);
    div_ovf  = (a == MOST_NEG) && (b == ALL_ONES);
    // Keep the divider away from its undefined cases; those results are muxed below.
    div_b    = (div_zero || div_ovf) ? ONE : b;
    prod_s   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    quot_s   = $signed(a) / $signed(div_b);
    rem_s    = $signed(a) % $signed(div_b);
    quot_u   = a / div_b;
    rem_u    = a % div_b;
    calc_hi  = '0;
    calc_lo  = '0;
    case (op)
      OP_MULT:  {calc_hi, calc_lo} = prod_s;
      OP_MULTU: {calc_hi, calc_lo} = prod_u;
      OP_DIV: begin
        if (div_zero) begin
          calc_hi = a;
          calc_lo = ALL_ONES;
        end else if (div_ovf) begin
          calc_hi = '0;
          calc_lo = a;
        end else begin
          calc_hi = rem_s;
          calc_lo = quot_s;
        end
      end
      OP_DIVU: begin
        if (div_zero) begin
          calc_hi = a;
          calc_lo = ALL_ONES;
        end else begin
          calc_hi = rem_u;
          calc_lo = quot_u;
        end
      end
      default: ;
    endcase
  end

  // Next-state: accept a start only when idle; finish on the edge where cnt is 1.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Cycle counter and held result; counter is loaded with N on the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
    end else if (accept) begin
      cnt    <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      res_hi <= calc_hi;
      res_lo <= calc_lo;
    end else if (state == RUN) begin
      cnt    <= cnt - CW'(1);
    end
  end

  // HI/LO: result write on completion; MTHI/MTLO only when idle and not starting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (state == IDLE && !start) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  assign busy      = (state == RUN);
  assign stall_req = busy | start;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: default 32-bit instance plus a 16-bit instance.
// Inputs driven and outputs sampled around the falling edge.
// Every wait on busy is bounded by a cycle budget.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  logic        p_start, p_hi_we, p_lo_we;
  logic [1:0]  p_op;
  logic [15:0] p_a, p_b, p_wdata;
  logic        p_busy, p_stall_req;
  logic [15:0] p_hi, p_lo;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .start(p_start), .op(p_op), .a(p_a), .b(p_b),
    .hi_we(p_hi_we), .lo_we(p_lo_we), .wdata(p_wdata),
    .busy(p_busy), .stall_req(p_stall_req), .hi(p_hi), .lo(p_lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Launch one op, check stall_req in the start cycle, count busy cycles, check HI/LO.
  task automatic run_op(input bit sel, input string tag, input logic [1:0] o,
                        input logic [31:0] av, input logic [31:0] bv, input bit hwe,
                        input int n, input logic [31:0] eh, input logic [31:0] el);
    int cycles;
    @(negedge clk);
    if (sel) begin
      p_start = 1'b1; p_op = o; p_a = av[15:0]; p_b = bv[15:0];
    end else begin
      start = 1'b1; op = o; a = av; b = bv; hi_we = hwe; wdata = 32'hDEAD_BEEF;
    end
    #1;
    check({tag, "_stall"}, {31'd0, (sel ? p_stall_req : stall_req)}, 32'd1);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; p_start = 1'b0;
    cycles = 0;
    while ((sel ? p_busy : busy) && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, cycles, n);
    if (sel) begin
      check({tag, "_hi"}, {16'd0, p_hi}, eh);
      check({tag, "_lo"}, {16'd0, p_lo}, el);
    end else begin
      check({tag, "_hi"}, hi, eh);
      check({tag, "_lo"}, lo, el);
    end
  endtask

  initial begin
    int cycles;
    reset = 1'b1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'b00; a = '0; b = '0; wdata = '0;
    p_start = 1'b0; p_hi_we = 1'b0; p_lo_we = 1'b0; p_op = 2'b00; p_a = '0; p_b = '0; p_wdata = '0;

    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // MTHI and MTLO together in idle.
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_1357;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both_hi", hi, 32'h0000_1357);
    check("mt_both_lo", lo, 32'h0000_1357);

    // Reset in cycle 3 of a DIV: immediate clear, no late write.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_hi", hi, 32'd0);
    check("postrst_lo", lo, 32'd0);

    run_op(0, "mult",   2'b00, 32'hFFFF_FFFD, 32'd7, 0, 5,  32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(0, "multu",  2'b01, 32'hFFFF_FFFD, 32'd7, 0, 5,  32'h0000_0006, 32'hFFFF_FFEB);
    run_op(0, "div",    2'b10, 32'hFFFF_FFF9, 32'd2, 0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(0, "div_nb", 2'b10, 32'd7, 32'hFFFF_FFFE, 0, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op(0, "divu",   2'b11, 32'd7, 32'd2, 0, 10, 32'd1, 32'd3);
    run_op(0, "divu0",  2'b11, 32'h0000_1234, 32'd0, 0, 10, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op(0, "div0",   2'b10, 32'hFFFF_FFFB, 32'd0, 0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op(0, "divovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 10, 32'd0, 32'h8000_0000);

    // start, MTHI and MTLO during RUN are all ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      if (cycles == 2) begin
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_00AA;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("cont_cycles", cycles, 32'd5);
    check("cont_hi", hi, 32'd0);
    check("cont_lo", lo, 32'd42);
    repeat (3) @(negedge clk);
    check("cont_noqueue", {31'd0, busy}, 32'd0);
    check("cont_lo_hold", lo, 32'd42);

    // MTLO in idle lands on the next edge.
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h0000_00AA;
    #1;
    check("mtlo_before", lo, 32'd42);
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h0000_00AA);
    check("mtlo_hi", hi, 32'd0);

    // start with hi_we: the op result wins.
    run_op(0, "start_hiwe", 2'b01, 32'd3, 32'd5, 1, 5, 32'd0, 32'd15);

    // 16-bit instance, 1-cycle multiply and 3-cycle divide.
    run_op(1, "w16_mult", 2'b00, 32'h0000_8000, 32'h0000_8000, 0, 1, 32'h0000_4000, 32'h0000_0000);
    run_op(1, "w16_div",  2'b10, 32'h0000_FFF9, 32'h0000_0002, 0, 3, 32'h0000_FFFF, 32'h0000_FFFD);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
